// File: rtl/voting_machine_multi_pkg.sv
// voting_machine_multi_pkg: shared FSM state type and button one-hot check for the voting machine.
package voting_pkg;
  localparam int VM_MAX_CAND = 32;
  typedef enum logic [1:0] {OPEN, HOLD, TALLY, DONE} vm_state_e;
  function automatic logic onehot(input logic [VM_MAX_CAND-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/voting_machine_multi_tally_scan.sv
// vm_tally_scan: walks the candidate counters one per cycle, tracking the running max and a tie flag.
module vm_tally_scan #(
  parameter int N_CAND = 3,
  parameter int CNT_W = 6,
  localparam int IDX_W = $clog2(N_CAND)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [IDX_W-1:0] best_idx_o,
  output logic             tie_o,
  output logic             done_o
);
  logic busy_q, done_q, tie_q;
  logic [CNT_W-1:0] best_q;
  logic [IDX_W-1:0] idx_q, best_idx_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tie_q <= 1'b0;
      best_q <= '0;
      idx_q <= '0;
      best_idx_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
      tie_q <= 1'b0;
      best_q <= '0;
      idx_q <= '0;
      best_idx_q <= '0;
    end else if (busy_q) begin
      // an equal count at idx 0 is never a tie: it is only matching the zero seed
      if (cnt_i > best_q) begin
        best_q <= cnt_i;
        best_idx_q <= idx_q;
        tie_q <= 1'b0;
      end else if (cnt_i == best_q && idx_q != '0)
        tie_q <= 1'b1;
      if (idx_q == IDX_W'(N_CAND-1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else
        idx_q <= idx_q + 1'b1;
    end
  assign idx_o = idx_q;
  assign best_idx_o = best_idx_q;
  assign tie_o = tie_q;
  assign done_o = done_q;
endmodule

// File: rtl/voting_machine_multi.sv
// voting_machine_multi: N-candidate vote counter with press rejection, close-of-poll tally and winner/tie report.
module voting_machine_multi
  import voting_pkg::*;
#(
  parameter int N_CAND = 3,
  parameter int CNT_W = 6,
  localparam int IDX_W = $clog2(N_CAND)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CAND-1:0]       i_candidate,
  input  logic                    i_voting_over,
  output logic [N_CAND*CNT_W-1:0] o_count,
  output logic                    o_vote_ok,
  output logic                    o_vote_rej,
  output logic                    o_result_valid,
  output logic [IDX_W-1:0]        o_winner,
  output logic                    o_tie
);
  vm_state_e state_q, state_d;
  logic [N_CAND-1:0] btn_q, sat;
  logic vote_ok_q, vote_rej_q, vote_ok_d, vote_rej_d, accept, start, scan_done;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt [N_CAND];
  // closing the poll wins over any press evaluated on the same edge
  always_comb begin
    start = (state_q == OPEN || state_q == HOLD) && i_voting_over;
    accept = state_q == OPEN && !i_voting_over && btn_q != '0;
    vote_ok_d = accept && onehot(VM_MAX_CAND'(btn_q)) && (btn_q & sat) == '0;
    vote_rej_d = accept && !vote_ok_d;
    state_d = start ? TALLY :
              (state_q == OPEN && btn_q != '0) ? HOLD :
              (state_q == HOLD && btn_q == '0) ? OPEN :
              (state_q == TALLY && scan_done) ? DONE : state_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= OPEN;
      btn_q <= '0;
      vote_ok_q <= 1'b0;
      vote_rej_q <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q <= i_candidate;
      vote_ok_q <= vote_ok_d;
      vote_rej_q <= vote_rej_d;
    end
  for (genvar k = 0; k < N_CAND; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else if (vote_ok_d && btn_q[k]) cnt_q <= cnt_q + 1'b1;
    assign cnt[k] = cnt_q;
    assign sat[k] = &cnt_q;
    assign o_count[k*CNT_W +: CNT_W] = cnt_q;
  end
  vm_tally_scan #(.N_CAND(N_CAND), .CNT_W(CNT_W)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .cnt_i     (cnt[idx]),
    .idx_o     (idx),
    .best_idx_o(o_winner),
    .tie_o     (o_tie),
    .done_o    (scan_done)
  );
  assign o_vote_ok = vote_ok_q;
  assign o_vote_rej = vote_rej_q;
  assign o_result_valid = state_q == DONE;
endmodule

// File: tb/tb_voting_machine_multi.sv
// tb_voting_machine_multi: directed checks of voting, rejection, saturation, tally latency and reset.
module tb_voting_machine_multi;
  logic clk = 0, rst = 0, vo = 0;
  logic [2:0] cand = '0;
  logic [17:0] cnt_a;
  logic [5:0] cnt_b;
  logic ok_a, rej_a, val_a, tie_a, ok_b, rej_b, val_b, tie_b;
  logic [1:0] win_a, win_b;
  int errors = 0, checks = 0, nok_a = 0, nrej_a = 0, nok_b = 0, nrej_b = 0, s_ok, s_rej;
  always #5 clk = ~clk;
  voting_machine_multi #(.N_CAND(3), .CNT_W(6)) dut_a (
    .clk(clk), .rst(rst), .i_candidate(cand), .i_voting_over(vo), .o_count(cnt_a),
    .o_vote_ok(ok_a), .o_vote_rej(rej_a), .o_result_valid(val_a), .o_winner(win_a), .o_tie(tie_a));
  voting_machine_multi #(.N_CAND(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .i_candidate(cand), .i_voting_over(vo), .o_count(cnt_b),
    .o_vote_ok(ok_b), .o_vote_rej(rej_b), .o_result_valid(val_b), .o_winner(win_b), .o_tie(tie_b));
  always @(negedge clk) begin
    if (ok_a) nok_a++;
    if (rej_a) nrej_a++;
    if (ok_b) nok_b++;
    if (rej_b) nrej_b++;
    checks++;
    if ((ok_a && rej_a) || (ok_b && rej_b)) begin
      errors++;
      $display("FAIL pulse_excl: ok/rej a=%b%b b=%b%b, required not both high", ok_a, rej_a, ok_b, rej_b);
    end
  end
  task automatic press(input logic [2:0] m, input int n);
    cand = m;
    repeat (n) @(negedge clk);
    cand = '0;
    repeat (3) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 0; cand = '0; vo = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 0;
    #2;
    checks++;
    if ({cnt_a, ok_a, rej_a, val_a, win_a, tie_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %h required 0", {cnt_a, ok_a, rej_a, val_a, win_a, tie_a});
    end
    checks++;
    if ({cnt_b, ok_b, rej_b, val_b, win_b, tie_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got %h required 0", {cnt_b, ok_b, rej_b, val_b, win_b, tie_b});
    end
    do_reset();
  endtask
  task automatic test_votes();
    s_ok = nok_a; s_rej = nrej_a;
    press(3'b001, 2); press(3'b010, 1); press(3'b001, 1); press(3'b100, 1);
    press(3'b010, 1); press(3'b010, 1); press(3'b001, 1); press(3'b100, 1);
    checks++;
    if (cnt_a !== {6'd2, 6'd3, 6'd3}) begin
      errors++;
      $display("FAIL votes_count: got %h required %h", cnt_a, {6'd2, 6'd3, 6'd3});
    end
    checks++;
    if (nok_a - s_ok !== 8) begin
      errors++;
      $display("FAIL votes_ok_pulses: got %0d required 8", nok_a - s_ok);
    end
    checks++;
    if (nrej_a - s_rej !== 0) begin
      errors++;
      $display("FAIL votes_rej_pulses: got %0d required 0", nrej_a - s_rej);
    end
  endtask
  task automatic test_tally();
    vo = 1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (val_a !== (k == 4)) begin
        errors++;
        $display("FAIL tally_latency: after edge %0d valid=%b required %b", k, val_a, k == 4);
      end
    end
    checks++;
    if (win_a !== 2'd0 || tie_a !== 1'b1) begin
      errors++;
      $display("FAIL tally_result: winner=%0d tie=%b required winner=0 tie=1", win_a, tie_a);
    end
    vo = 0;
  endtask
  task automatic test_multi_press();
    do_reset();
    s_ok = nok_a; s_rej = nrej_a;
    press(3'b011, 1);
    checks++;
    if (nrej_a - s_rej !== 1 || nok_a - s_ok !== 0 || cnt_a !== '0) begin
      errors++;
      $display("FAIL multi_press: rej=%0d ok=%0d count=%h required rej=1 ok=0 count=0", nrej_a - s_rej, nok_a - s_ok, cnt_a);
    end
    cand = 3'b011;
    repeat (2) @(negedge clk);
    cand = 3'b001;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_a !== '0 || nok_a - s_ok !== 0 || nrej_a - s_rej !== 2) begin
      errors++;
      $display("FAIL hold_release: count=%h ok=%0d rej=%0d required count=0 ok=0 rej=2", cnt_a, nok_a - s_ok, nrej_a - s_rej);
    end
    cand = '0;
    repeat (3) @(negedge clk);
    press(3'b001, 1);
    checks++;
    if (cnt_a !== {6'd0, 6'd0, 6'd1} || nok_a - s_ok !== 1) begin
      errors++;
      $display("FAIL vote_after_release: count=%h ok=%0d required count=%h ok=1", cnt_a, nok_a - s_ok, {6'd0, 6'd0, 6'd1});
    end
  endtask
  task automatic test_saturate();
    do_reset();
    s_ok = nok_b; s_rej = nrej_b;
    repeat (3) press(3'b100, 1);
    checks++;
    if (cnt_b !== {2'd3, 2'd0, 2'd0} || nok_b - s_ok !== 3 || nrej_b - s_rej !== 0) begin
      errors++;
      $display("FAIL sat_fill: count=%h ok=%0d rej=%0d required count=%h ok=3 rej=0", cnt_b, nok_b - s_ok, nrej_b - s_rej, {2'd3, 2'd0, 2'd0});
    end
    press(3'b100, 1);
    checks++;
    if (cnt_b !== {2'd3, 2'd0, 2'd0} || nok_b - s_ok !== 3 || nrej_b - s_rej !== 1) begin
      errors++;
      $display("FAIL sat_reject: count=%h ok=%0d rej=%0d required count=%h ok=3 rej=1", cnt_b, nok_b - s_ok, nrej_b - s_rej, {2'd3, 2'd0, 2'd0});
    end
    vo = 1;
    repeat (6) @(negedge clk);
    checks++;
    if (val_b !== 1'b1 || win_b !== 2'd2 || tie_b !== 1'b0) begin
      errors++;
      $display("FAIL sat_tally: valid=%b winner=%0d tie=%b required valid=1 winner=2 tie=0", val_b, win_b, tie_b);
    end
    vo = 0;
  endtask
  task automatic test_vo_priority();
    do_reset();
    s_ok = nok_a; s_rej = nrej_a;
    cand = 3'b010; vo = 1;
    @(negedge clk);
    cand = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (cnt_a !== '0 || nok_a - s_ok !== 0 || nrej_a - s_rej !== 0) begin
      errors++;
      $display("FAIL vo_priority: count=%h ok=%0d rej=%0d required all 0", cnt_a, nok_a - s_ok, nrej_a - s_rej);
    end
    checks++;
    if (val_a !== 1'b1 || win_a !== 2'd0 || tie_a !== 1'b1) begin
      errors++;
      $display("FAIL zero_votes: valid=%b winner=%0d tie=%b required valid=1 winner=0 tie=1", val_a, win_a, tie_a);
    end
    vo = 0;
    press(3'b001, 2);
    press(3'b110, 1);
    checks++;
    if (cnt_a !== '0 || nok_a - s_ok !== 0 || nrej_a - s_rej !== 0 || val_a !== 1'b1) begin
      errors++;
      $display("FAIL done_frozen: count=%h ok=%0d rej=%0d valid=%b required 0/0/0/1", cnt_a, nok_a - s_ok, nrej_a - s_rej, val_a);
    end
  endtask
  task automatic test_mid_reset();
    do_reset();
    press(3'b001, 1);
    vo = 1;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if ({cnt_a, ok_a, rej_a, val_a, win_a, tie_a} !== '0) begin
      errors++;
      $display("FAIL mid_tally_reset: got %h required 0", {cnt_a, ok_a, rej_a, val_a, win_a, tie_a});
    end
    @(negedge clk);
    vo = 0; rst = 1;
    @(negedge clk);
    s_ok = nok_a;
    press(3'b010, 1);
    checks++;
    if (cnt_a !== {6'd0, 6'd1, 6'd0} || nok_a - s_ok !== 1 || val_a !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_vote: count=%h ok=%0d valid=%b required count=%h ok=1 valid=0", cnt_a, nok_a - s_ok, val_a, {6'd0, 6'd1, 6'd0});
    end
  endtask
  initial begin
    test_reset();
    test_votes();
    test_tally();
    test_multi_press();
    test_saturate();
    test_vo_priority();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
